// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookups read registered state only; updates and clears take effect on the next edge.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              clear,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_ONE << (CTR_W - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr, ctr_d;
  logic             unused_pc_bits;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Byte-offset bits never select an entry; instructions are word aligned.
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup path: purely combinational from registered table state, no update bypass.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ctr_q[upd_idx];

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ctr_d = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) ctr_d = upd_ctr + CTR_ONE;
    end else if (upd_ctr != '0) begin
      ctr_d = upd_ctr - CTR_ONE;
    end
  end

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid && (stat_branches_q != '1))
      stat_branches_d = stat_branches_q + STAT_W'(1);
    if (mispredict && (stat_mispredicts_q != '1))
      stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
  end

  // NOTE: the table is reset explicitly because an empty, zero-counter table must be
  // visible the moment reset asserts; a memory without reset could not guarantee that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_d;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        // Taken miss replaces whatever occupied the slot, starting weakly taken.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
